mem_port_arbiter: RTL and testbench

Single-port arbiter and boot sequencer for the CPU's unified 256×8 memory. Instruction fetch, the MEM-stage data path (loads, stores, stack push/pop) and an external program loader all share one memory port. After reset the block fetches the reset vector before releasing the pipeline. It sits between the CPU pipeline and the memory instance inside the CPU wrapper, and drives the fetch-stall signal the hazard unit consumes.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/prio_sel.sv | 32 +++
 rtl/mem_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: arbiter FSM states, requester ids, boot vector default.
package cpu_pkg;

  typedef enum logic [1:0] {
    BOOT_RD = 2'd0,
    BOOT_WT = 2'd1,
    RUN     = 2'd2
  } arb_state_t;

  localparam logic [1:0] RID_F = 2'd0;
  localparam logic [1:0] RID_D = 2'd1;
  localparam logic [1:0] RID_L = 2'd2;

  localparam logic [7:0] RESET_VEC_DEFAULT = 8'h00;

endpackage : cpu_pkg

// File: rtl/prio_sel.sv
// Three-way fixed-priority grant: loader > data > fetch, with a boost that
// lifts fetch above data (the loader still wins).
module prio_sel (
  input  logic en,
  input  logic l_req,
  input  logic d_req,
  input  logic f_req,
  input  logic f_boost,
  output logic l_gnt,
  output logic d_gnt,
  output logic f_gnt
);

  // At most one grant; nothing is granted while disabled.
  always_comb begin
    l_gnt = 1'b0;
    d_gnt = 1'b0;
    f_gnt = 1'b0;
    if (en) begin
      if (l_req) begin
        l_gnt = 1'b1;
      end else if (f_boost && f_req) begin
        f_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end else if (f_req) begin
        f_gnt = 1'b1;
      end
    end
  end

endmodule : prio_sel

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter and boot sequencer for the unified 256x8 memory.
// Fetches the reset vector after reset, then arbitrates loader/data/fetch.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter logic [7:0]  RESET_VEC    = RESET_VEC_DEFAULT,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       ld_req,
  input  logic       ld_we,
  input  logic [7:0] ld_addr,
  input  logic [7:0] ld_wdata,
  output logic       ld_gnt,
  input  logic       d_req,
  input  logic       d_we,
  input  logic [7:0] d_addr,
  input  logic [7:0] d_wdata,
  output logic       d_gnt,
  input  logic       f_req,
  input  logic [7:0] f_addr,
  output logic       f_gnt,
  output logic       f_stall,
  output logic       rvalid,
  output logic [1:0] rid,
  output logic [7:0] rdata,
  output logic       boot_valid,
  output logic [7:0] boot_pc,
  output logic       mem_en,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata
);

  localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  arb_state_t    state;
  arb_state_t    state_nxt;
  logic [SW-1:0] starve;
  logic          f_boost;
  logic          run;
  logic          issue_rd;
  logic [1:0]    issue_id;
  logic [7:0]    boot_pc_q;
  logic          rvalid_q;
  logic [1:0]    rid_q;

  assign run     = (state == RUN);
  assign f_boost = (starve == STARVE_MAX);

  prio_sel u_prio_sel (
    .en      (run),
    .l_req   (ld_req),
    .d_req   (d_req),
    .f_req   (f_req),
    .f_boost (f_boost),
    .l_gnt   (ld_gnt),
    .d_gnt   (d_gnt),
    .f_gnt   (f_gnt)
  );

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= BOOT_RD;
    end else begin
      state <= state_nxt;
    end
  end

  // Boot sequence: one vector read, one capture cycle, then run forever.
  always_comb begin
    state_nxt = state;
    unique case (state)
      BOOT_RD: state_nxt = BOOT_WT;
      BOOT_WT: state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = BOOT_RD;
    endcase
  end

  // Memory port mux: boot read, or the single granted requester.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    issue_id  = RID_F;
    if (state == BOOT_RD) begin
      mem_en   = 1'b1;
      mem_addr = RESET_VEC;
    end else if (ld_gnt) begin
      mem_en    = 1'b1;
      mem_we    = ld_we;
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
      issue_id  = RID_L;
    end else if (d_gnt) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      issue_id  = RID_D;
    end else if (f_gnt) begin
      mem_en   = 1'b1;
      mem_addr = f_addr;
      issue_id = RID_F;
    end
  end

  assign issue_rd = (ld_gnt || d_gnt || f_gnt) && !mem_we;

  // Fetch starvation counter, saturating at the limit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve <= '0;
    end else if (f_req && !f_gnt) begin
      if (starve != STARVE_MAX) begin
        starve <= starve + 1'b1;
      end
    end else begin
      starve <= '0;
    end
  end

  // Read-return tag: remembers who issued last cycle's read.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rvalid_q <= 1'b0;
      rid_q    <= RID_F;
    end else begin
      rvalid_q <= issue_rd;
      if (issue_rd) begin
        rid_q <= issue_id;
      end
    end
  end

  // Boot PC holding register, loaded as the vector byte returns.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      boot_pc_q <= '0;
    end else if (state == BOOT_WT) begin
      boot_pc_q <= mem_rdata;
    end
  end

  // The vector byte arrives during BOOT_WT, so boot_pc forwards it while the
  // pulse is high and the register holds it from then on.
  assign boot_valid = (state == BOOT_WT);
  assign boot_pc    = boot_valid ? mem_rdata : boot_pc_q;

  assign rvalid  = rvalid_q;
  assign rid     = rid_q;
  assign rdata   = rvalid_q ? mem_rdata : '0;
  assign f_stall = !run || (f_req && !f_gnt);

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a synchronous 256x8 memory model.
module tb_mem_port_arbiter;

  logic       clk = 1'b0;
  logic       rstn;
  logic       ld_req, ld_we;
  logic [7:0] ld_addr, ld_wdata;
  logic       ld_gnt;
  logic       d_req, d_we;
  logic [7:0] d_addr, d_wdata;
  logic       d_gnt;
  logic       f_req;
  logic [7:0] f_addr;
  logic       f_gnt, f_stall;
  logic       rvalid;
  logic [1:0] rid;
  logic [7:0] rdata;
  logic       boot_valid;
  logic [7:0] boot_pc;
  logic       mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  logic [7:0] mem [256];
  logic       preload;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.RESET_VEC(8'h00), .STARVE_LIMIT(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .ld_req     (ld_req),
    .ld_we      (ld_we),
    .ld_addr    (ld_addr),
    .ld_wdata   (ld_wdata),
    .ld_gnt     (ld_gnt),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_gnt      (d_gnt),
    .f_req      (f_req),
    .f_addr     (f_addr),
    .f_gnt      (f_gnt),
    .f_stall    (f_stall),
    .rvalid     (rvalid),
    .rid        (rid),
    .rdata      (rdata),
    .boot_valid (boot_valid),
    .boot_pc    (boot_pc),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  function automatic logic [7:0] init_byte(input int unsigned a);
    logic [7:0] v;
    v = 8'(a) ^ 8'h5A;
    if (a == 0)   v = 8'h0A;
    if (a == 128) v = 8'hC3;
    return v;
  endfunction

  // Memory model: one-cycle read latency, write on enable.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_byte(i);
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; preload = 1'b1;
    ld_req = 0; ld_we = 0; ld_addr = '0; ld_wdata = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    f_req = 0; f_addr = '0;
    tick; tick; tick;

    // Reset state; loader held off.
    ld_req = 1'b1; #1;
    chk("rst_f_stall", f_stall, 1);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rid", rid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_boot_valid", boot_valid, 0);
    chk("rst_boot_pc", boot_pc, 8'h00);
    chk("rst_ld_gnt", ld_gnt, 0);
    ld_req = 1'b0;

    // Boot.
    tick; rstn = 1'b1; preload = 1'b0; #1;
    chk("boot_rd_en", mem_en, 1);
    chk("boot_rd_we", mem_we, 0);
    chk("boot_rd_addr", mem_addr, 8'h00);
    chk("boot_rd_stall", f_stall, 1);
    chk("boot_rd_bv", boot_valid, 0);
    tick; #1;
    chk("boot_wt_bv", boot_valid, 1);
    chk("boot_wt_pc", boot_pc, 8'h0A);
    chk("boot_wt_stall", f_stall, 1);
    tick; #1;
    chk("run_bv", boot_valid, 0);
    chk("run_pc", boot_pc, 8'h0A);
    chk("run_stall", f_stall, 0);

    // Fetch-only, back-to-back.
    f_req = 1'b1;
    for (int unsigned a = 10; a <= 12; a++) begin
      f_addr = 8'(a); #1;
      chk("fo_gnt", f_gnt, 1);
      chk("fo_stall", f_stall, 0);
      chk("fo_addr", mem_addr, a);
      tick;
      chk("fo_rvalid", rvalid, 1);
      chk("fo_rid", rid, 0);
      chk("fo_rdata", rdata, init_byte(a));
    end
    f_req = 1'b0; #1;
    tick;
    chk("fo_idle_rvalid", rvalid, 0);

    // Contention then starvation: data wins 4 cycles, fetch wins the 5th.
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h80;
    f_req = 1'b1; f_addr = 8'd20;
    for (int unsigned c = 1; c <= 6; c++) begin
      #1;
      chk("st_f_gnt", f_gnt, (c == 5) ? 1 : 0);
      chk("st_d_gnt", d_gnt, (c == 5) ? 0 : 1);
      chk("st_f_stall", f_stall, (c == 5) ? 0 : 1);
      tick;
      chk("st_rvalid", rvalid, 1);
      chk("st_rid", rid, (c == 5) ? 0 : 1);
      chk("st_rdata", rdata, (c == 5) ? init_byte(20) : 8'hC3);
    end
    d_req = 1'b0; f_req = 1'b0;
    tick;

    // Simultaneous loader write and data write: loader first.
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'd42; d_wdata = 8'd38;
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 8'h50; ld_wdata = 8'hFF; #1;
    chk("wr_ld_gnt", ld_gnt, 1);
    chk("wr_d_gnt0", d_gnt, 0);
    chk("wr_ld_we", mem_we, 1);
    chk("wr_ld_addr", mem_addr, 8'h50);
    chk("wr_ld_wdata", mem_wdata, 8'hFF);
    tick; ld_req = 1'b0; #1;
    chk("wr_rvalid0", rvalid, 0);
    chk("wr_d_gnt1", d_gnt, 1);
    chk("wr_d_addr", mem_addr, 8'd42);
    chk("wr_d_wdata", mem_wdata, 8'd38);
    tick; d_req = 1'b0; #1;
    chk("wr_rvalid1", rvalid, 0);
    chk("wr_mem50", mem[8'h50], 8'hFF);
    chk("wr_mem42", mem[42], 8'd38);

    // Read back via data port and loader.
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h50; #1;
    tick; d_req = 1'b0;
    chk("rb_d_rid", rid, 1);
    chk("rb_d_rdata", rdata, 8'hFF);
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 8'd42; #1;
    chk("rb_ld_gnt", ld_gnt, 1);
    tick; ld_req = 1'b0;
    chk("rb_ld_rvalid", rvalid, 1);
    chk("rb_ld_rid", rid, 2);
    chk("rb_ld_rdata", rdata, 8'd38);

    // Mid-run reset right after a read grant.
    f_req = 1'b1; f_addr = 8'd30; #1;
    chk("mr_f_gnt", f_gnt, 1);
    tick; rstn = 1'b0; f_req = 1'b0; #1;
    chk("mr_rvalid", rvalid, 0);
    chk("mr_stall", f_stall, 1);
    chk("mr_bv", boot_valid, 0);
    tick; rstn = 1'b1; #1;
    chk("mr_boot_addr", mem_addr, 8'h00);
    chk("mr_boot_en", mem_en, 1);
    chk("mr_rvalid2", rvalid, 0);
    tick;
    chk("mr_bv_pulse", boot_valid, 1);
    chk("mr_boot_pc", boot_pc, 8'h0A);
    tick;
    chk("mr_run_stall", f_stall, 0);
    chk("mr_run_bv", boot_valid, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_mem_port_arbiter
